// File: rtl/hid_pkg.sv
// Shared keycode constants, FSM state encoding and key_mask bit positions
// for the HID boot-keyboard movement encoder.
package hid_pkg;

  localparam logic [7:0] KEY_W        = 8'h1A;
  localparam logic [7:0] KEY_A        = 8'h04;
  localparam logic [7:0] KEY_S        = 8'h16;
  localparam logic [7:0] KEY_D        = 8'h07;
  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;

  // key_mask layout is {W,S,D,A}
  localparam int MASK_W = 3;
  localparam int MASK_S = 2;
  localparam int MASK_D = 1;
  localparam int MASK_A = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOD    = 3'd1,
    ST_KEYS   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FLUSH  = 3'd4
  } state_e;

  function automatic logic [3:0] key_bits(input logic [7:0] code);
    logic [3:0] m;
    m         = '0;
    m[MASK_W] = (code == KEY_W);
    m[MASK_S] = (code == KEY_S);
    m[MASK_D] = (code == KEY_D);
    m[MASK_A] = (code == KEY_A);
    return m;
  endfunction

endpackage

// File: rtl/hid_key_prio.sv
// Combinational movement-key priority encoder: W > A > D > S, KEY_NONE when
// no movement key is held. Zero latency, no flow control.
module hid_key_prio
  import hid_pkg::*;
(
  input  logic [3:0] mask_i,
  output logic [7:0] keycode_o
);

  always_comb begin
    keycode_o = KEY_NONE;
    if (mask_i[MASK_W])      keycode_o = KEY_W;
    else if (mask_i[MASK_A]) keycode_o = KEY_A;
    else if (mask_i[MASK_D]) keycode_o = KEY_D;
    else if (mask_i[MASK_S]) keycode_o = KEY_S;
  end

endmodule

// File: rtl/hid_keycode_encoder.sv
// Boot-keyboard report parser -> single movement keycode; commit one cycle after rpt_last,
// rpt_ready low only in COMMIT and the first FLUSH cycle. HID_ROLLOVER_FILTER_EN drops 8'h01 reports.
module hid_keycode_encoder
  import hid_pkg::*;
#(
  parameter int REPORT_BYTES   = 8,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       rpt_valid,
  output logic       rpt_ready,
  input  logic [7:0] rpt_data,
  input  logic       rpt_last,
  output logic [7:0] keycode,
  output logic [3:0] key_mask,
  output logic       keycode_upd,
  output logic       rpt_err
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]      LAST_IDX = 3'(REPORT_BYTES - 1);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      shadow_q, shadow_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      keycode_q, keycode_d;
  logic [3:0]      mask_q, mask_d;
  logic            upd_q, upd_d;
  logic            err_q, err_d;
  logic            xfer, at_last, commit, wd_hit, roll_hit;
  logic [7:0]      prio_code;

  assign xfer    = rpt_valid && rpt_ready;
  assign at_last = (cnt_q == LAST_IDX);

`ifdef HID_ROLLOVER_FILTER_EN
  logic roll_q, roll_d;

  assign roll_hit = roll_q || (rpt_data == KEY_ROLLOVER);

  always_comb begin
    roll_d = roll_q;
    if (state_q == ST_KEYS && xfer && rpt_data == KEY_ROLLOVER) roll_d = 1'b1;
    if (state_d == ST_IDLE || state_d == ST_FLUSH)              roll_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) roll_q <= 1'b0;
    else          roll_q <= roll_d;
  end
`else
  assign roll_hit = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // The modifier (byte 0) and reserved (byte 1) bytes carry no movement keys.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (xfer && !rpt_last) state_d = ST_MOD;
      ST_MOD:    if (xfer) state_d = rpt_last ? ST_IDLE : ST_KEYS;
      ST_KEYS: begin
        if (xfer) begin
          if (at_last)       state_d = !rpt_last ? ST_FLUSH : (roll_hit ? ST_IDLE : ST_COMMIT);
          else if (rpt_last) state_d = ST_IDLE;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_FLUSH:  if (xfer && rpt_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rpt_ready = 1'b1;
    err_d     = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE, ST_MOD: err_d = rpt_valid && rpt_last;
      ST_KEYS:         err_d = rpt_valid && (at_last ? !rpt_last : rpt_last);
      ST_COMMIT: begin
        rpt_ready = 1'b0;
        commit    = 1'b1;
      end
      ST_FLUSH:        rpt_ready = (cnt_q != 3'd0);
      default:         ;
    endcase
  end

  // cnt doubles as the FLUSH "ready opened" flag: 0 on entry, 1 afterwards.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (state_d != state_q)             cnt_d = (state_d == ST_KEYS) ? 3'd2 : 3'd0;
    else if (state_q == ST_KEYS && xfer) cnt_d = cnt_q + 3'd1;
    else if (state_q == ST_FLUSH)        cnt_d = 3'd1;
    if (state_q == ST_KEYS && xfer)                 shadow_d = shadow_q | key_bits(rpt_data);
    if (state_d == ST_IDLE || state_d == ST_FLUSH)  shadow_d = '0;
  end

  hid_key_prio u_prio (
    .mask_i    (shadow_q),
    .keycode_o (prio_code)
  );

  assign wd_hit = !commit && (wd_q == WD_MAX - 1'b1);

  always_comb begin
    wd_d      = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    keycode_d = keycode_q;
    mask_d    = mask_q;
    upd_d     = 1'b0;
    if (commit) begin
      wd_d      = '0;
      keycode_d = prio_code;
      mask_d    = shadow_q;
      upd_d     = 1'b1;
    end else if (wd_hit) begin
      keycode_d = KEY_NONE;
      mask_d    = '0;
      upd_d     = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q     <= '0;
      shadow_q  <= '0;
      wd_q      <= '0;
      keycode_q <= KEY_NONE;
      mask_q    <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      wd_q      <= wd_d;
      keycode_q <= keycode_d;
      mask_q    <= mask_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
    end
  end

  assign keycode     = keycode_q;
  assign key_mask    = mask_q;
  assign keycode_upd = upd_q;
  assign rpt_err     = err_q;

endmodule

// File: tb/tb_hid_keycode_encoder.sv
// Directed bench for hid_keycode_encoder with a 16-cycle watchdog.
module tb_hid_keycode_encoder;

  logic       Clk, Reset_n, rpt_valid, rpt_ready, rpt_last, keycode_upd, rpt_err;
  logic [7:0] rpt_data, keycode;
  logic [3:0] key_mask;
  int         vectors     = 0;
  int         miscompares = 0;
  int         pulses, first_k;

  hid_keycode_encoder #(.REPORT_BYTES(8), .TIMEOUT_CYCLES(16)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_data    (rpt_data),
    .rpt_last    (rpt_last),
    .keycode     (keycode),
    .key_mask    (key_mask),
    .keycode_upd (keycode_upd),
    .rpt_err     (rpt_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge that took the byte.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    rpt_valid = 1'b1;
    rpt_data  = d;
    rpt_last  = l;
    while (rpt_ready !== 1'b1 && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 20) begin
      miscompares++;
      $display("FAIL ready_stall: rpt_ready=%b after %0d cycles, expected 1", rpt_ready, n);
    end
    @(posedge Clk); #1;
    rpt_valid = 1'b0;
    rpt_last  = 1'b0;
  endtask

  // Byte i of the report is r[71-8*i -: 8]; last_idx outside 0..nbytes-1 means no rpt_last.
  task automatic send_rpt(input logic [71:0] r, input int nbytes, input int last_idx);
    for (int i = 0; i < nbytes; i++) send_byte(r[71-8*i -: 8], i == last_idx);
  endtask

  task automatic expect_commit(input string tag, input logic [7:0] kc, input logic [3:0] m);
    chk({tag, "_upd_early"}, keycode_upd, 0);
    chk({tag, "_ready_commit"}, rpt_ready, 0);
    @(posedge Clk); #1;
    chk({tag, "_upd"}, keycode_upd, 1);
    chk({tag, "_keycode"}, keycode, kc);
    chk({tag, "_mask"}, key_mask, m);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, expected summary");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    Reset_n   = 1'b0;
    rpt_valid = 1'b0;
    rpt_data  = 8'h00;
    rpt_last  = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_keycode", keycode, 8'h00);
    chk("rst_mask", key_mask, 4'h0);
    chk("rst_upd", keycode_upd, 0);
    chk("rst_err", rpt_err, 0);
    chk("rst_ready", rpt_ready, 1);
    Reset_n = 1'b1;

    // Single W key
    send_rpt({64'h0000_1A00_0000_0000, 8'h00}, 8, 7);
    expect_commit("w_only", 8'h1A, 4'b1000);

    // D, A, S plus a duplicate A: A wins
    send_rpt({64'h0000_0704_1604_0000, 8'h00}, 8, 7);
    expect_commit("das", 8'h04, 4'b0111);

    // Short report: error, outputs held, next report commits
    send_rpt({64'h0000_1A00_0000_0000, 8'h00}, 5, 4);
    chk("short_err", rpt_err, 1);
    chk("short_keycode", keycode, 8'h04);
    chk("short_mask", key_mask, 4'b0111);
    chk("short_upd", keycode_upd, 0);
    @(posedge Clk); #1;
    chk("short_err_pulse", rpt_err, 0);
    send_rpt({64'h0000_0700_0000_0000, 8'h00}, 8, 7);
    expect_commit("d_only", 8'h07, 4'b0010);

    // Watchdog: exactly one clearing pulse 16 cycles after the commit
    pulses  = 0;
    first_k = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge Clk); #1;
      if (k == 15) chk("pre_timeout_keycode", keycode, 8'h07);
      if (keycode_upd === 1'b1) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("timeout_pulses", pulses, 1);
    chk("timeout_cycle", first_k, 16);
    chk("timeout_keycode", keycode, 8'h00);
    chk("timeout_mask", key_mask, 4'h0);

    // rpt_last on byte 0
    send_byte(8'h00, 1'b1);
    chk("b0_last_err", rpt_err, 1);
    chk("b0_last_upd", keycode_upd, 0);

    // Nine-byte report: error at byte 7, flush, no commit
    send_rpt({64'h0000_1A00_0000_0000, 8'h00}, 8, 99);
    chk("long_err", rpt_err, 1);
    chk("flush_ready_low", rpt_ready, 0);
    send_byte(8'h00, 1'b1);
    chk("flush_end_err", rpt_err, 0);
    @(posedge Clk); #1;
    chk("flush_no_upd", keycode_upd, 0);
    chk("flush_keycode", keycode, 8'h00);
    send_rpt({64'h0000_041A_0000_0000, 8'h00}, 8, 7);
    expect_commit("after_flush", 8'h1A, 4'b1001);

    // Reset in the middle of a report
    send_rpt({64'h0000_1A00_0000_0000, 8'h00}, 4, 99);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_keycode", keycode, 8'h00);
    chk("midrst_mask", key_mask, 4'h0);
    chk("midrst_upd", keycode_upd, 0);
    chk("midrst_err", rpt_err, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    send_rpt({64'h0000_0400_0000_0000, 8'h00}, 8, 7);
    expect_commit("post_rst", 8'h04, 4'b0001);

    // Commit lands on the watchdog's final cycle: commit wins
    repeat (7) begin
      @(posedge Clk); #1;
    end
    send_rpt({64'h0000_1600_0000_0000, 8'h00}, 8, 7);
    expect_commit("coincide", 8'h16, 4'b0100);
    @(posedge Clk); #1;
    chk("coincide_no_extra_upd", keycode_upd, 0);
    chk("coincide_hold", keycode, 8'h16);

    // Report containing ErrorRollOver
    send_rpt({64'h0000_1A01_0000_0000, 8'h00}, 8, 7);
`ifdef HID_ROLLOVER_FILTER_EN
    chk("roll_err", rpt_err, 0);
    @(posedge Clk); #1;
    chk("roll_no_upd", keycode_upd, 0);
    chk("roll_keycode", keycode, 8'h16);
    chk("roll_mask", key_mask, 4'b0100);
    chk("roll_err_late", rpt_err, 0);
`else
    expect_commit("roll_plain", 8'h1A, 4'b1000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
